rd_burst_seq: RTL and testbench
===============================

# rd_burst_seq

Parametrised read-strobe sequencer and successor to the two-state-output read FSM. It accepts a `go` request, issues a burst of 1..2^BEAT_W read beats with wait-state handshaking on `ws`, then pulses `ds` for one cycle. `rd` and `ds` are driven directly from flops, so the outputs cannot glitch. It sits between the bus-request logic and the external read strobe pads. An optional per-beat watchdog aborts a stalled beat.

## Interface
- `BEAT_W`, default 4: width of `burst_len` and `beat_idx`; maximum burst is 2^BEAT_W beats.
- `WAIT_W`, default 8: width of the per-beat wait counter.
- `MAX_WAIT`, default 200: timeout limit in DLY cycles with `ws=1`. Range is 1 ≤ MAX_WAIT ≤ 2^WAIT_W−1. Used only with `RD_TIMEOUT_EN`.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `go` in 1: start request, sampled only in IDLE.
- `burst_len` in BEAT_W: number of beats minus one, latched when `go` is accepted.
- `ws` in 1: wait-state input; 1 means the target is not ready and the beat is extended.
- `rd` out 1: read strobe, registered.
- `ds` out 1: data-strobe/done pulse, registered.
- `busy` out 1: high in every state except IDLE, registered.
- `beat_idx` out BEAT_W: index of the current beat, 0-based, registered.
- `err` out 1: one-cycle timeout-abort pulse, registered.

## Operation
- States: IDLE, READ, DLY, DONE, ERR.
- All outputs are flops loaded from the next-state decode, so each output changes on the same edge as the state register.
- Output encoding per state:
  - IDLE: rd=0, ds=0, busy=0, err=0.
  - READ and DLY: rd=1, ds=0, busy=1.
  - DONE: rd=0, ds=1, busy=1.
  - ERR: rd=0, ds=0, err=1, busy=1.
- IDLE: `go=1` → READ, latch `burst_len` into `len_q`, clear `beat_idx` and the wait counter. `go=0` → stay in IDLE.
- READ: always → DLY after exactly one cycle. Clear the wait counter.
- DLY, evaluated in this order:
  - `ws=0` and `beat_idx==len_q` → DONE.
  - `ws=0` and `beat_idx<len_q` → READ, `beat_idx`+1.
  - `ws=1` and timeout reached (macro on) → ERR.
  - `ws=1` otherwise → stay in DLY, wait counter +1.
- DONE: always → IDLE after exactly one cycle.
- ERR: always → IDLE after exactly one cycle. `beat_idx` holds the aborted beat's index while in ERR.
- In IDLE, `beat_idx` holds its last value.
- `go` outside IDLE is ignored. It is not queued.
- A `go` held high through DONE restarts in the first cycle after returning to IDLE.
- `burst_len=0` produces a single beat.
- `burst_len=2^BEAT_W−1` produces the full burst; `beat_idx` reaches its all-ones value without wrapping.
- The wait counter saturates and never wraps. Its width is checked by assertion: MAX_WAIT must fit in WAIT_W.

## Timing
- Reset (asynchronous assert) forces the state to IDLE and all outputs to 0 (`rd`, `ds`, `busy`, `beat_idx`, `err`), and clears `len_q` and the wait counter immediately, mid-burst included. Release is synchronous to `clk`.
- Latency: `go` sampled at edge E → `rd` and `busy` rise at edge E.
- Minimum beat is 2 cycles of `rd=1` (READ plus one DLY cycle with `ws=0`). Each `ws=1` cycle in DLY adds one cycle.
- `rd` stays continuously high across beats of a burst. There is no low gap between DLY and the next READ.
- `ds` rises on the edge after the last beat's `ws=0` sample and is high for exactly 1 cycle.
- Single beat with no waits: `go` sampled at E0; `rd` high for E0–E2; `ds` high for E2–E3; back in IDLE at E3.
- Timeout: ERR is entered on the edge where DLY samples `ws=1` for the MAX_WAIT-th consecutive cycle in the same beat.

## Configuration
- `RD_TIMEOUT_EN` defined: the wait counter and the ERR transition are compiled in.
- `RD_TIMEOUT_EN` undefined: the wait counter and ERR logic are removed, `err` is tied to 0, and DLY waits indefinitely while `ws=1`. All other behaviour is identical.

## Test plan
- Single beat: `burst_len=0`, `go` pulse, `ws=0` → `rd` high 2 cycles, then `ds` high 1 cycle, `busy` high 3 cycles, `err=0`.
- Burst with waits: `burst_len=3`, `ws=1` for 2 cycles in each DLY → `rd` high continuously for 4×(1+1+2)=16 cycles, `beat_idx` steps 0,1,2,3, then a single `ds` pulse.
- Timeout (macro on, MAX_WAIT=5): `ws` held at 1 → `rd` drops after 1+5 cycles, `err` pulses 1 cycle, `ds` never asserts, `busy` falls the cycle after ERR.
- `go` held high continuously with `burst_len=1` → bursts repeat back to back. `go` during READ, DLY or DONE never shortens or restarts the active burst.
- Reset mid-burst: assert `reset_n=0` during DLY of beat 2 → `rd`, `ds`, `busy`, `beat_idx` and `err` are 0 immediately; after release, a `go` starts a fresh burst at `beat_idx=0`.
- Macro off: `ws=1` for 1000 cycles → `rd` stays 1 and `err` stays 0; dropping `ws` completes the beat normally.

Source files
------------

// File: rtl/rd_burst_seq_if.sv
// Request/strobe bundle between the bus-request logic (master) and the
// read-strobe sequencer (slave).
interface rd_burst_seq_if #(
  parameter int BEAT_W = 4
);
  logic              go;
  logic [BEAT_W-1:0] burst_len;
  logic              ws;
  logic              rd;
  logic              ds;
  logic              busy;
  logic [BEAT_W-1:0] beat_idx;
  logic              err;

  modport master (
    output go, burst_len, ws,
    input  rd, ds, busy, beat_idx, err
  );

  modport slave (
    input  go, burst_len, ws,
    output rd, ds, busy, beat_idx, err
  );
endinterface

// File: rtl/rd_burst_seq.sv
// Glitch-free read-strobe burst sequencer: go -> 1..2^BEAT_W beats with ws wait
// states -> one-cycle ds. Optional per-beat watchdog enabled by RD_TIMEOUT_EN.
module rd_burst_seq #(
  parameter int BEAT_W   = 4,
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 200
) (
  input  logic           clk,
  input  logic           reset_n,
  rd_burst_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DLY,
    S_DONE,
    S_ERR
  } state_t;

  if ((MAX_WAIT < 1) || (MAX_WAIT > (2**WAIT_W) - 1)) begin : g_max_wait_chk
    $error("rd_burst_seq: MAX_WAIT does not fit in WAIT_W");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BEAT_W-1:0] r_len;
  logic [BEAT_W-1:0] w_len_nxt;
  logic [BEAT_W-1:0] r_beat;
  logic [BEAT_W-1:0] w_beat_nxt;
  logic              r_rd;
  logic              r_ds;
  logic              r_busy;

`ifdef RD_TIMEOUT_EN
  logic [WAIT_W-1:0] r_wcnt;
  logic [WAIT_W-1:0] w_wcnt_nxt;
  logic              w_timeout;
  logic              r_err;

  // This ws=1 sample is the MAX_WAIT-th one of the current beat.
  assign w_timeout = (r_wcnt == WAIT_W'(MAX_WAIT - 1));
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_beat_nxt  = r_beat;
`ifdef RD_TIMEOUT_EN
    w_wcnt_nxt  = r_wcnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.go) begin
          w_state_nxt = S_READ;
          w_len_nxt   = bus.burst_len;
          w_beat_nxt  = '0;
`ifdef RD_TIMEOUT_EN
          w_wcnt_nxt  = '0;
`endif
        end
      end
      S_READ: begin
        w_state_nxt = S_DLY;
`ifdef RD_TIMEOUT_EN
        w_wcnt_nxt  = '0;
`endif
      end
      S_DLY: begin
        if (!bus.ws) begin
          if (r_beat == r_len) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_READ;
            w_beat_nxt  = r_beat + 1'b1;
          end
        end
`ifdef RD_TIMEOUT_EN
        else if (w_timeout) begin
          w_state_nxt = S_ERR;
        end else if (r_wcnt != '1) begin
          w_wcnt_nxt = r_wcnt + 1'b1;
        end
`endif
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are loaded from the next-state decode so they switch with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_beat  <= '0;
      r_rd    <= 1'b0;
      r_ds    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_beat  <= w_beat_nxt;
      r_rd    <= (w_state_nxt == S_READ) || (w_state_nxt == S_DLY);
      r_ds    <= (w_state_nxt == S_DONE);
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

`ifdef RD_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wcnt <= w_wcnt_nxt;
      r_err  <= (w_state_nxt == S_ERR);
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.rd       = r_rd;
  assign bus.ds       = r_ds;
  assign bus.busy     = r_busy;
  assign bus.beat_idx = r_beat;

endmodule

// File: tb/tb_rd_burst_seq.sv
// Directed bench for rd_burst_seq: per-cycle expected {rd,ds,busy,err,beat_idx}
// vectors go through a scoreboard queue and are compared at the falling edge.
module tb_rd_burst_seq;
  localparam int BEAT_W   = 4;
  localparam int WAIT_W   = 8;
  localparam int MAX_WAIT = 5;

  logic clk = 1'b0;
  logic reset_n;

  rd_burst_seq_if #(.BEAT_W(BEAT_W)) bus ();

  rd_burst_seq #(
    .BEAT_W  (BEAT_W),
    .WAIT_W  (WAIT_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [7:0] pk(input logic rd, input logic ds, input logic busy,
                                    input logic err, input logic [3:0] idx);
    return {rd, ds, busy, err, idx};
  endfunction

  task automatic compare(input string tag);
    logic [7:0] obs;
    logic [7:0] e;
    obs = {bus.rd, bus.ds, bus.busy, bus.err, bus.beat_idx};
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      n_assert++;
      assert (obs === e)
      else begin
        n_fail++;
        $error("FAIL %s: observed {rd,ds,busy,err,idx}=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  // Drive inputs for the coming edge, record the expected post-edge outputs.
  task automatic step(input string tag, input logic go, input logic ws, input logic [7:0] e);
    bus.go = go;
    bus.ws = ws;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    compare(tag);
  endtask

  // One complete burst of len+1 beats, each beat stretched by 'waits' ws=1 cycles.
  task automatic burst(input string tag, input logic [3:0] len, input int waits,
                       input logic hold_go);
    bus.burst_len = len;
    step({tag, ":start"}, 1'b1, 1'b0, pk(1, 0, 1, 0, 4'd0));
    bus.burst_len = ~len;
    for (int b = 0; b <= int'(len); b++) begin
      step({tag, ":dly"}, hold_go, 1'b0, pk(1, 0, 1, 0, 4'(b)));
      for (int w = 0; w < waits; w++)
        step({tag, ":wait"}, hold_go, 1'b1, pk(1, 0, 1, 0, 4'(b)));
      if (b == int'(len))
        step({tag, ":done"}, hold_go, 1'b0, pk(0, 1, 1, 0, len));
      else
        step({tag, ":next"}, hold_go, 1'b0, pk(1, 0, 1, 0, 4'(b + 1)));
    end
    step({tag, ":idle"}, hold_go, 1'b0, pk(0, 0, 0, 0, len));
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.go        = 1'b0;
    bus.ws        = 1'b0;
    bus.burst_len = '0;

    @(negedge clk);
    exp_q.push_back(pk(0, 0, 0, 0, 4'd0));
    compare("reset_hold");
    step("reset_go_ignored", 1'b1, 1'b0, pk(0, 0, 0, 0, 4'd0));
    reset_n = 1'b1;
    step("idle_after_reset", 1'b0, 1'b0, pk(0, 0, 0, 0, 4'd0));

    burst("single", 4'd0, 0, 1'b0);
    step("idle_hold", 1'b0, 1'b0, pk(0, 0, 0, 0, 4'd0));
    burst("waits", 4'd3, 2, 1'b0);
    step("idle_idx_hold", 1'b0, 1'b1, pk(0, 0, 0, 0, 4'd3));
    burst("full", 4'd15, 0, 1'b0);
    burst("b2b_a", 4'd1, 0, 1'b1);
    burst("b2b_b", 4'd1, 1, 1'b1);
    step("b2b_end", 1'b0, 1'b0, pk(0, 0, 0, 0, 4'd1));

`ifdef RD_TIMEOUT_EN
    burst("just_under_timeout", 4'd1, MAX_WAIT - 1, 1'b0);
    bus.burst_len = 4'd2;
    step("to:start", 1'b1, 1'b0, pk(1, 0, 1, 0, 4'd0));
    step("to:dly", 1'b0, 1'b1, pk(1, 0, 1, 0, 4'd0));
    for (int i = 0; i < MAX_WAIT - 1; i++)
      step("to:wait", 1'b0, 1'b1, pk(1, 0, 1, 0, 4'd0));
    step("to:err", 1'b0, 1'b1, pk(0, 0, 1, 1, 4'd0));
    step("to:idle", 1'b0, 1'b1, pk(0, 0, 0, 0, 4'd0));
    step("to:quiet", 1'b0, 1'b0, pk(0, 0, 0, 0, 4'd0));
`else
    burst("long_wait", 4'd0, 1000, 1'b0);
`endif

    // Abort a burst during the DLY phase of beat 2.
    bus.burst_len = 4'd3;
    step("rst:start", 1'b1, 1'b0, pk(1, 0, 1, 0, 4'd0));
    for (int b = 0; b < 2; b++) begin
      step("rst:dly", 1'b0, 1'b0, pk(1, 0, 1, 0, 4'(b)));
      step("rst:next", 1'b0, 1'b0, pk(1, 0, 1, 0, 4'(b + 1)));
    end
    step("rst:dly2", 1'b0, 1'b1, pk(1, 0, 1, 0, 4'd2));
    #2 reset_n = 1'b0;
    #1;
    exp_q.push_back(pk(0, 0, 0, 0, 4'd0));
    compare("rst:async_clear");
    @(negedge clk);
    exp_q.push_back(pk(0, 0, 0, 0, 4'd0));
    compare("rst:held");
    reset_n = 1'b1;
    step("rst:idle", 1'b0, 1'b0, pk(0, 0, 0, 0, 4'd0));
    burst("after_reset", 4'd1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
